// File: rtl/multi_rate_divider.sv
// multi_rate_divider
//   Derives NUM_CH independent divided rates from a single master clock.
//   Each channel produces a one-cycle tick every div[c] enabled cycles and a
//   square wave that toggles on every tick. Divide ratios can be reloaded at
//   run time; illegal loads are dropped and latch a sticky error flag.
//
// Ports
//   masterclk  in   master clock, all state on posedge
//   rst        in   synchronous active-high reset
//   en         in   global count enable
//   sync       in   restart every channel counter (phase align)
//   ld         in   divide-ratio load strobe
//   ld_ch      in   [1:0] channel targeted by ld
//   ld_div     in   [CNT_W-1:0] new divide ratio (must be non-zero)
//   tick       out  [NUM_CH-1:0] one-cycle strobe per channel
//   sq         out  [NUM_CH-1:0] square wave per channel, period 2*div
//   err        out  sticky illegal-load flag, cleared only by rst

// One divider channel: ratio register, counter, registered tick and sq.
module mrd_chan #(
   parameter int               CNT_W   = 27,
   parameter logic [CNT_W-1:0] DIV_RST = '1
) (
   input  logic             masterclk,
   input  logic             rst,
   input  logic             en,
   input  logic             sync,
   input  logic             ld_hit,
   input  logic [CNT_W-1:0] ld_div,
   output logic             tick,
   output logic             sq
);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] div;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] div_m1;

   // Terminal count is div-1 so wrap never depends on counter overflow.
   assign div_m1 = div - ONE;

   always_ff @(posedge masterclk) begin
      if (rst) begin
         div  <= DIV_RST;
         cnt  <= '0;
         tick <= 1'b0;
         sq   <= 1'b0;
      end else begin
         if (ld_hit)
            div <= ld_div;
         // Load and sync both restart the count; sq keeps its phase.
         if (sync || ld_hit) begin
            cnt  <= '0;
            tick <= 1'b0;
         end else if (en) begin
            if (cnt == div_m1) begin
               cnt  <= '0;
               tick <= 1'b1;
               sq   <= ~sq;
            end else begin
               cnt  <= cnt + ONE;
               tick <= 1'b0;
            end
         end else begin
            tick <= 1'b0;
         end
      end
   end
endmodule

module multi_rate_divider #(
   parameter int                      NUM_CH   = 3,
   parameter int                      CNT_W    = 27,
   parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {27'd100000, 27'd50000000, 27'd100000000}
) (
   input  logic              masterclk,
   input  logic              rst,
   input  logic              en,
   input  logic              sync,
   input  logic              ld,
   input  logic [1:0]        ld_ch,
   input  logic [CNT_W-1:0]  ld_div,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] sq,
   output logic              err
);
   localparam logic [2:0] NCH = 3'(NUM_CH);

   logic ld_ok;

   // A load is accepted only for an existing channel and a non-zero ratio.
   assign ld_ok = ld && ({1'b0, ld_ch} < NCH) && (ld_div != '0);

   always_ff @(posedge masterclk) begin
      if (rst)
         err <= 1'b0;
      else if (ld && !ld_ok)
         err <= 1'b1;
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      mrd_chan #(
         .CNT_W   (CNT_W),
         .DIV_RST (DIV_INIT[c*CNT_W +: CNT_W])
      ) u_ch (
         .masterclk (masterclk),
         .rst       (rst),
         .en        (en),
         .sync      (sync),
         .ld_hit    (ld_ok && (ld_ch == 2'(c))),
         .ld_div    (ld_div),
         .tick      (tick[c]),
         .sq        (sq[c])
      );
   end
endmodule

// File: tb/tb_multi_rate_divider.sv
// Directed bench for multi_rate_divider with NUM_CH=3, CNT_W=8,
// ratios ch0=4, ch1=3, ch2=2. Edge numbering counts from the last reset edge.
module tb_multi_rate_divider;
   localparam int NUM_CH = 3;
   localparam int CNT_W  = 8;

   logic              masterclk = 1'b0;
   logic              rst, en, sync, ld;
   logic [1:0]        ld_ch;
   logic [CNT_W-1:0]  ld_div;
   logic [NUM_CH-1:0] tick, sq;
   logic              err;

   int total = 0;
   int bad   = 0;

   always #5 masterclk = ~masterclk;

   multi_rate_divider #(
      .NUM_CH   (NUM_CH),
      .CNT_W    (CNT_W),
      .DIV_INIT ({8'd2, 8'd3, 8'd4})
   ) dut (
      .masterclk (masterclk),
      .rst       (rst),
      .en        (en),
      .sync      (sync),
      .ld        (ld),
      .ld_ch     (ld_ch),
      .ld_div    (ld_div),
      .tick      (tick),
      .sq        (sq),
      .err       (err)
   );

   // Advance one edge; outputs are sampled and inputs changed 1 time unit later.
   task automatic step();
      @(posedge masterclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bits are {ch2, ch1, ch0}, entries for edges 1..12 after reset.
   logic [2:0] tick_tab [0:11] = '{3'b000, 3'b100, 3'b010, 3'b101, 3'b000, 3'b110,
                                   3'b000, 3'b101, 3'b010, 3'b100, 3'b000, 3'b111};
   logic [2:0] sq_tab   [0:11] = '{3'b000, 3'b100, 3'b110, 3'b011, 3'b011, 3'b101,
                                   3'b101, 3'b000, 3'b010, 3'b110, 3'b110, 3'b001};

   initial begin
      rst = 1'b1; en = 1'b1; sync = 1'b0; ld = 1'b0; ld_ch = 2'd0; ld_div = 8'd0;
      step();
      step();                              // edge 0: last reset edge
      chk("rst_tick", 8'(tick), 8'h0);
      chk("rst_sq",   8'(sq),   8'h0);
      chk("rst_err",  8'(err),  8'h0);
      rst = 1'b0;

      // edges 1..12: free running
      for (int i = 0; i < 12; i++) begin
         step();
         chk($sformatf("run_tick_e%0d", i + 1), 8'(tick), 8'(tick_tab[i]));
         chk($sformatf("run_sq_e%0d",   i + 1), 8'(sq),   8'(sq_tab[i]));
      end

      // edge 13 enabled, edges 14..18 paused
      step();                              // e13
      chk("e13_tick", 8'(tick), 8'h0);
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("pause_tick_%0d", i), 8'(tick), 8'h0);
         chk($sformatf("pause_sq_%0d",   i), 8'(sq),   8'b001);
      end
      en = 1'b1;
      step(); chk("resume_e19", 8'(tick), 8'b100);
      step(); chk("resume_e20", 8'(tick), 8'b010);
      step(); chk("resume_e21", 8'(tick), 8'b101);
      chk("resume_sq_e21", 8'(sq), 8'b010);

      // sync at edge 22
      sync = 1'b1;
      step();
      sync = 1'b0;
      chk("sync_tick", 8'(tick), 8'h0);
      chk("sync_sq",   8'(sq),   8'b010);
      step(); chk("sync_e23", 8'(tick), 8'b000);
      step(); chk("sync_e24", 8'(tick), 8'b100);
      step(); chk("sync_e25", 8'(tick), 8'b010);
      step(); chk("sync_e26", 8'(tick), 8'b101);
      chk("sync_sq_e26", 8'(sq), 8'b001);

      // load ch0 with ratio 1 at edge 27
      ld = 1'b1; ld_ch = 2'd0; ld_div = 8'd1;
      step();
      ld = 1'b0;
      chk("ld1_tick", 8'(tick), 8'b000);
      chk("ld1_sq0",  8'(sq[0]), 8'h1);
      step(); chk("div1_e28", 8'(tick), 8'b111);
      chk("div1_sq_e28", 8'(sq[0]), 8'h0);
      step(); chk("div1_e29", 8'(tick[0]), 8'h1); chk("div1_sq_e29", 8'(sq[0]), 8'h1);
      step(); chk("div1_e30", 8'(tick[0]), 8'h1); chk("div1_sq_e30", 8'(sq[0]), 8'h0);
      step(); chk("div1_e31", 8'(tick[0]), 8'h1); chk("div1_sq_e31", 8'(sq[0]), 8'h1);

      // illegal loads: channel 3, then ratio 0 to ch1
      ld = 1'b1; ld_ch = 2'd3; ld_div = 8'd5;
      step();                              // e32
      chk("badch_err",   8'(err),     8'h1);
      chk("badch_tick0", 8'(tick[0]), 8'h1);
      ld_ch = 2'd1; ld_div = 8'd0;
      step();                              // e33
      ld = 1'b0;
      chk("div0_err", 8'(err), 8'h1);
      step();                              // e34: ch1 keeps its phase
      chk("div0_tick1", 8'(tick[1]), 8'h1);
      chk("err_sticky", 8'(err),     8'h1);

      // full reset restores ratios and clears err
      rst = 1'b1;
      step();                              // e35
      rst = 1'b0;
      chk("rst2_err", 8'(err), 8'h0);
      step();                              // e36: cnt0=1
      ld = 1'b1; ld_ch = 2'd3;
      step();                              // e37: cnt0=2, err set, sq2=1
      ld = 1'b0;
      chk("pre_rst_err", 8'(err), 8'h1);
      chk("pre_rst_sq",  8'(sq),  8'b100);
      rst = 1'b1;
      step();                              // e38
      rst = 1'b0;
      chk("midrst_tick", 8'(tick), 8'h0);
      chk("midrst_sq",   8'(sq),   8'h0);
      chk("midrst_err",  8'(err),  8'h0);
      step(); chk("post_rst_1", 8'(tick[0]), 8'h0);
      step(); chk("post_rst_2", 8'(tick[0]), 8'h0);
      step(); chk("post_rst_3", 8'(tick[0]), 8'h0);
      step(); chk("post_rst_4", 8'(tick[0]), 8'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
